// File: rtl/servo_pkg.sv
// servo_pkg: tick-conversion helpers, width type and sequencer states shared by the servo bank
package servo_pkg;

  localparam int FCLK_DEF     = 50_000_000;
  localparam int FRAME_HZ_DEF = 50;

  function automatic int frame_ticks(input int fclk, input int hz);
    return fclk / hz;
  endfunction

  function automatic int us_to_ticks(input int fclk, input int us);
    return fclk / 1_000_000 * us;
  endfunction

  localparam int W = $clog2(frame_ticks(FCLK_DEF, FRAME_HZ_DEF));

  typedef logic [W-1:0] width_t;

  typedef enum logic [1:0] {IDLE, CALC, DRAIN} seq_state_t;

endpackage

// File: rtl/servo_scaler.sv
// servo_scaler: 2-stage magnitude-to-width pipeline (multiply, then offset; slew clamp with SERVO_SLEW_EN)
module servo_scaler import servo_pkg::*; #(
  parameter int N_CH       = 16,
  parameter int MAG_W      = 17,
  parameter int CH_W       = 4,
  parameter int MIN_TICKS  = 50_000,
  parameter int SPAN_TICKS = 50_000
`ifdef SERVO_SLEW_EN
  ,
  parameter int SLEW_TICKS = 1_000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [MAG_W-1:0] in_mag,
`ifdef SERVO_SLEW_EN
  input  width_t           in_cur_w,
`endif
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output width_t           out_w
);

  localparam int PW = MAG_W + $clog2(SPAN_TICKS + 1);

  logic            s1_valid;
  logic [CH_W-1:0] s1_ch;
  logic [PW-1:0]   s1_prod;
  width_t          target;

`ifdef SERVO_SLEW_EN
  localparam int DW = $bits(width_t) + 2;
  localparam logic signed [DW-1:0] SLEW = DW'(SLEW_TICKS);
  width_t                s1_cur;
  logic signed [DW-1:0]  diff;
`endif

  // Stage 1: register the unsigned magnitude*span product alongside its channel tag
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else s1_valid <= in_valid;
    s1_ch   <= in_ch;
    s1_prod <= PW'(in_mag) * PW'(SPAN_TICKS);
`ifdef SERVO_SLEW_EN
    s1_cur  <= in_cur_w;
`endif
  end

  assign target    = width_t'(MIN_TICKS) + width_t'(s1_prod >> MAG_W);
  assign out_valid = s1_valid;
  assign out_ch    = s1_ch;

`ifdef SERVO_SLEW_EN
  assign diff  = $signed({2'b00, target}) - $signed({2'b00, s1_cur});
  assign out_w = diff > SLEW  ? s1_cur + width_t'(SLEW_TICKS) :
                 diff < -SLEW ? s1_cur - width_t'(SLEW_TICKS) : target;
`else
  assign out_w = target;
`endif

endmodule

// File: rtl/servo_bank.sv
// servo_bank: N-channel servo PWM from one frame counter, double-buffered widths (slew limit with SERVO_SLEW_EN)
module servo_bank import servo_pkg::*; #(
  parameter int N_CH     = 16,
  parameter int MAG_W    = 17,
  parameter int FCLK     = FCLK_DEF,
  parameter int FRAME_HZ = FRAME_HZ_DEF,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int SLEW_US  = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CH-1:0][MAG_W-1:0]  mag,
  input  logic                        mag_valid,
  input  logic [N_CH-1:0]             ch_en,
  output logic [N_CH-1:0]             pulse_out,
  output logic                        frame_strobe,
  output logic                        busy
);

  localparam int FRAME_TICKS = frame_ticks(FCLK, FRAME_HZ);
  localparam int MIN_TICKS   = us_to_ticks(FCLK, MIN_US);
  localparam int SPAN_TICKS  = us_to_ticks(FCLK, MAX_US - MIN_US);
  localparam int CW          = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam width_t MID_W     = width_t'(MIN_TICKS + SPAN_TICKS / 2);
  localparam width_t LAST_TICK = width_t'(FRAME_TICKS - 1);
  localparam logic [MAG_W-1:0] SNAP_RST = {1'b1, {(MAG_W-1){1'b0}}};

  if (MAX_US <= MIN_US || N_CH + 3 >= FRAME_TICKS ||
      $clog2(FRAME_TICKS) > $bits(width_t) || SLEW_US < 0) begin : g_bad_cfg
    $error("servo_bank: invalid configuration");
  end

  width_t                      frame_cnt;
  logic                        wrap;
  logic [N_CH-1:0]             ch_en_r;
  logic [N_CH-1:0][MAG_W-1:0]  snapshot;
  width_t                      active_w [N_CH];
  width_t                      next_w   [N_CH];
  seq_state_t                  state;
  logic [CW-1:0]               ch;
  logic                        drain;
  logic                        sc_valid;
  logic [CW-1:0]               sc_ch;
  width_t                      sc_w;

  assign wrap = frame_cnt == LAST_TICK;

  // Frame counter and strobe; widths and enables swap only on the wrap so a pulse never changes mid-frame
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt    <= '0;
      frame_strobe <= 1'b0;
      ch_en_r      <= '0;
      active_w     <= '{default: MID_W};
    end else begin
      frame_cnt    <= wrap ? '0 : frame_cnt + 1'b1;
      frame_strobe <= wrap;
      if (wrap) begin
        ch_en_r  <= ch_en;
        active_w <= next_w;
      end
    end
  end

  // Magnitude capture; the latest strobe wins and the channel being issued this cycle still reads the old value
  always_ff @(posedge clk) begin
    if (reset) snapshot <= {N_CH{SNAP_RST}};
    else if (mag_valid) snapshot <= mag;
  end

  // Sequencer: walk channels into the shared scaler right after each frame start, then let the pipe drain
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ch    <= '0;
      drain <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_cnt == '0) begin
          state <= CALC;
          ch    <= '0;
          busy  <= 1'b1;
        end
        CALC: if (ch == CW'(N_CH - 1)) begin
          state <= DRAIN;
          drain <= 1'b0;
        end else ch <= ch + 1'b1;
        DRAIN: begin
          drain <= 1'b1;
          if (drain) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  servo_scaler #(
    .N_CH      (N_CH),
    .MAG_W     (MAG_W),
    .CH_W      (CW),
    .MIN_TICKS (MIN_TICKS),
    .SPAN_TICKS(SPAN_TICKS)
`ifdef SERVO_SLEW_EN
    ,
    .SLEW_TICKS(us_to_ticks(FCLK, SLEW_US))
`endif
  ) u_scaler (
    .clk      (clk),
    .reset    (reset),
    .in_valid (state == CALC),
    .in_ch    (ch),
    .in_mag   (snapshot[ch]),
`ifdef SERVO_SLEW_EN
    .in_cur_w (active_w[ch]),
`endif
    .out_valid(sc_valid),
    .out_ch   (sc_ch),
    .out_w    (sc_w)
  );

  // Shadow widths written from the scaler output; they become active at the next wrap
  always_ff @(posedge clk) begin
    if (reset) next_w <= '{default: MID_W};
    else if (sc_valid) next_w[sc_ch] <= sc_w;
  end

  // Registered pulse compare; one cycle of lag makes each high time exactly active_w ticks
  always_ff @(posedge clk) begin
    if (reset) pulse_out <= '0;
    else for (int i = 0; i < N_CH; i++) pulse_out[i] <= ch_en_r[i] && (frame_cnt < active_w[i]);
  end

endmodule
